// File: rtl/icache_refill_ctrl_pkg.sv
// Shared fetch definitions for the I-cache refill path: state encoding, beat geometry, watchdog limit.
// Supplies fallback values for the global SIZE_PC / CACHE_WIDTH defines when the build does not provide them.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef CACHE_WIDTH
`define CACHE_WIDTH 256
`endif

package icache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } refill_state_t;

  localparam int unsigned REFILL_BEAT_WIDTH   = 64;
  localparam int unsigned REFILL_NUM_BEATS    = `CACHE_WIDTH / REFILL_BEAT_WIDTH;
  localparam int unsigned REFILL_OFFSET_BITS  = $clog2(`CACHE_WIDTH / 8);
  localparam logic [9:0]  REFILL_TIMEOUT_LIMIT = 10'd1023;

endpackage

// File: rtl/refill_beat_buffer.sv
// Beat assembler: a modulo-NUM_BEATS slot counter plus the block register each beat is written into.
// Beat 0 lands in the least-significant slot; the counter is held at zero while i_clr is high.
module refill_beat_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int NUM_BEATS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_clr,
  input  logic                            i_beat_vld,
  input  logic                            i_keep,
  input  logic [BEAT_WIDTH-1:0]           i_beat_dat,
  output logic                            o_last,
  output logic [BEAT_WIDTH*NUM_BEATS-1:0] o_block
);

  localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic [CW-1:0]                   r_cnt;
  logic [BEAT_WIDTH*NUM_BEATS-1:0] r_block;

  assign o_last  = (r_cnt == CW'(NUM_BEATS - 1));
  assign o_block = r_block;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_block <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_beat_vld) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      // Drained beats still advance the counter but never touch the block.
      if (i_keep) begin
        for (int i = 0; i < NUM_BEATS; i++) begin
          if (r_cnt == CW'(i)) r_block[i*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_dat;
        end
      end
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller: one block-aligned request per miss, beats assembled, single-cycle cache write.
// Optional refill watchdog is compiled in when REFILL_TIMEOUT_EN is defined.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEAT_WIDTH = REFILL_BEAT_WIDTH,
  parameter int NUM_BEATS  = `CACHE_WIDTH / BEAT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss_i,
  input  logic [`SIZE_PC-1:0]     missAddr_i,
  input  logic                    cancel_i,
  output logic                    memReqValid_o,
  input  logic                    memReqReady_i,
  output logic [`SIZE_PC-1:0]     memReqAddr_o,
  input  logic                    memRspValid_i,
  input  logic [BEAT_WIDTH-1:0]   memRspData_i,
  output logic                    wrEnable_o,
  output logic [`SIZE_PC-1:0]     wrAddr_o,
  output logic [`CACHE_WIDTH-1:0] instBlock_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned PC_W = `SIZE_PC;
  localparam logic [PC_W-1:0] OFFSET_MASK = PC_W'((1 << REFILL_OFFSET_BITS) - 1);

  refill_state_t r_state;
  refill_state_t w_nxt;
  logic [PC_W-1:0] r_addr;
  logic            r_req_vld;
  logic            r_wr_en;
  logic            w_beat;
  logic            w_last;
  logic            w_tmo_hit;
  logic [BEAT_WIDTH*NUM_BEATS-1:0] w_block;

  assign w_beat = memRspValid_i && ((r_state == FILL) || (r_state == DRAIN));

  refill_beat_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .NUM_BEATS  (NUM_BEATS)
  ) u_beat_buf (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (r_state == IDLE),
    .i_beat_vld (w_beat),
    .i_keep     (r_state == FILL),
    .i_beat_dat (memRspData_i),
    .o_last     (w_last),
    .o_block    (w_block)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  if (miss_i && !cancel_i) w_nxt = REQ;
      REQ: begin
        if (memReqReady_i)  w_nxt = cancel_i ? DRAIN : FILL;
        else if (cancel_i)  w_nxt = IDLE;
      end
      // A cancel on the final beat has nothing left to drain.
      FILL: begin
        if (w_beat && w_last) w_nxt = cancel_i ? IDLE : WRITE;
        else if (cancel_i)    w_nxt = DRAIN;
      end
      WRITE: w_nxt = IDLE;
      DRAIN: if (w_beat && w_last) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_tmo_hit) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_req_vld <= 1'b0;
      r_wr_en   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_req_vld <= (w_nxt == REQ);
      r_wr_en   <= (w_nxt == WRITE);
      if ((r_state == IDLE) && (w_nxt == REQ)) r_addr <= missAddr_i & ~OFFSET_MASK;
    end
  end

`ifdef REFILL_TIMEOUT_EN
  logic [9:0] r_tmo_cnt;
  logic       r_timeout;

  assign w_tmo_hit = (r_tmo_cnt == REFILL_TIMEOUT_LIMIT);
  assign timeout_o = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_tmo_hit) r_timeout <= 1'b1;
      if ((w_nxt != r_state) || w_beat)
        r_tmo_cnt <= '0;
      else if ((r_state == REQ) || (r_state == FILL) || (r_state == DRAIN))
        r_tmo_cnt <= r_tmo_cnt + 10'd1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign memReqValid_o = r_req_vld;
  assign memReqAddr_o  = r_addr;
  assign wrEnable_o    = r_wr_en;
  assign wrAddr_o      = r_addr;
  assign instBlock_o   = w_block;
  assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: transaction-level model of expected request address, block and write count.
module tb_icache_refill_ctrl;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         miss_i = 1'b0;
  logic [31:0]  missAddr_i = '0;
  logic         cancel_i = 1'b0;
  logic         memReqValid_o;
  logic         memReqReady_i = 1'b0;
  logic [31:0]  memReqAddr_o;
  logic         memRspValid_i = 1'b0;
  logic [63:0]  memRspData_i = '0;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;
  logic         timeout_o;

  int n_chk = 0;
  int n_err = 0;
  logic [287:0] wr_q[$];

  icache_refill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .miss_i        (miss_i),
    .missAddr_i    (missAddr_i),
    .cancel_i      (cancel_i),
    .memReqValid_o (memReqValid_o),
    .memReqReady_i (memReqReady_i),
    .memReqAddr_o  (memReqAddr_o),
    .memRspValid_i (memRspValid_i),
    .memRspData_i  (memRspData_i),
    .wrEnable_o    (wrEnable_o),
    .wrAddr_o      (wrAddr_o),
    .instBlock_o   (instBlock_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrEnable_o === 1'b1) wr_q.push_back({wrAddr_o, instBlock_o});
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare cache writes seen since the last call against the expected outcome.
  task automatic chk_writes(input int exp_n, input logic [31:0] exp_addr, input logic [255:0] exp_blk);
    logic [287:0] w;
    chk("wr_count", wr_q.size(), exp_n);
    if (exp_n == 1 && wr_q.size() > 0) begin
      w = wr_q.pop_front();
      chk("wr_q_addr", w[287:256], exp_addr);
      chk("wr_q_blk", w[255:0], exp_blk);
    end
    wr_q.delete();
  endtask

  task automatic refill(input logic [31:0] addr, input int rdy_dly, input int gmin, input int gmax,
                        input int cancel_k, input bit coinc, input bit stray, input bit fixed_dat);
    logic [31:0]  exp_addr;
    logic [255:0] exp_blk;
    logic [63:0]  d;
    int g;
    bit cxl;
    exp_addr = addr & ~32'h1F;
    exp_blk  = '0;
    cxl      = 1'b0;
    miss_i = 1'b1; missAddr_i = addr; step();
    miss_i = 1'b0; missAddr_i = $urandom();
    chk("req_vld", memReqValid_o, 1'b1);
    chk("req_addr", memReqAddr_o, exp_addr);
    chk("busy_req", busy_o, 1'b1);
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      chk("req_hold_vld", memReqValid_o, 1'b1);
      chk("req_hold_addr", memReqAddr_o, exp_addr);
    end
    memReqReady_i = 1'b1; step(); memReqReady_i = 1'b0;
    chk("req_drop", memReqValid_o, 1'b0);
    for (int b = 0; b < NB; b++) begin
      if (b == cancel_k && !coinc) begin
        cancel_i = 1'b1; step(); cancel_i = 1'b0; cxl = 1'b1;
      end
      g = $urandom_range(gmax, gmin);
      for (int i = 0; i < g; i++) begin
        miss_i = stray && (i == 0);
        missAddr_i = 32'h0000_2000;
        step();
      end
      miss_i = 1'b0;
      d = fixed_dat ? 64'hA + 64'(b) : {$urandom(), $urandom()};
      exp_blk[b*64 +: 64] = d;
      memRspValid_i = 1'b1; memRspData_i = d;
      if (b == cancel_k && coinc) begin
        cancel_i = 1'b1; cxl = 1'b1;
      end
      step();
      memRspValid_i = 1'b0; cancel_i = 1'b0;
    end
    cancel_i = 1'($urandom_range(1, 0));
    chk("wr_en", wrEnable_o, !cxl);
    chk("busy_wr", busy_o, !cxl);
    if (!cxl) begin
      chk("wr_addr", wrAddr_o, exp_addr);
      chk("wr_blk", instBlock_o, exp_blk);
      if (fixed_dat) chk("blk_DCBA", instBlock_o, {64'hD, 64'hC, 64'hB, 64'hA});
    end
    step();
    cancel_i = 1'b0;
    chk("wr_pulse_end", wrEnable_o, 1'b0);
    chk("busy_idle", busy_o, 1'b0);
    chk_writes(cxl ? 0 : 1, exp_addr, exp_blk);
  endtask

  task automatic req_cancel(input bit with_hs);
    int w;
    miss_i = 1'b1; missAddr_i = $urandom(); cancel_i = 1'b1; step();
    miss_i = 1'b0; cancel_i = 1'b0;
    chk("miss_cxl_busy", busy_o, 1'b0);
    miss_i = 1'b1; step(); miss_i = 1'b0;
    w = $urandom_range(2, 0);
    for (int i = 0; i < w; i++) step();
    cancel_i = 1'b1; memReqReady_i = with_hs; step();
    cancel_i = 1'b0; memReqReady_i = 1'b0;
    chk("cxl_req_vld", memReqValid_o, 1'b0);
    chk("cxl_busy", busy_o, with_hs);
    for (int b = 0; b < NB; b++) begin
      memRspValid_i = 1'b1; memRspData_i = {$urandom(), $urandom()}; step();
      memRspValid_i = 1'b0;
      if (b == NB - 2) chk("drain_busy", busy_o, with_hs);
    end
    chk("drain_done", busy_o, 1'b0);
    step();
    chk_writes(0, '0, '0);
  endtask

  initial begin
    int ck;
    bit co;
    #1;
    chk("rst_req_vld", memReqValid_o, 1'b0);
    chk("rst_req_addr", memReqAddr_o, '0);
    chk("rst_wr_en", wrEnable_o, 1'b0);
    chk("rst_wr_addr", wrAddr_o, '0);
    chk("rst_blk", instBlock_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_tmo", timeout_o, 1'b0);
    step(); step();
    reset = 1'b1;
    step();

    refill(32'h0000_1234, 0, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    refill(32'h0000_5678, 5, 2, 2, -1, 1'b0, 1'b0, 1'b0);
    refill(32'h0000_9ABC, 0, 1, 1,  2, 1'b0, 1'b0, 1'b0);
    refill(32'h0000_4444, 1, 0, 1, -1, 1'b0, 1'b0, 1'b0);
    refill(32'h0000_1220, 1, 1, 2, -1, 1'b0, 1'b1, 1'b0);
    req_cancel(1'b0);
    req_cancel(1'b1);

    // Reset in FILL after the first beat.
    miss_i = 1'b1; missAddr_i = 32'h0000_7770; step(); miss_i = 1'b0;
    memReqReady_i = 1'b1; step(); memReqReady_i = 1'b0;
    memRspValid_i = 1'b1; memRspData_i = 64'h1111; step(); memRspValid_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_req_vld", memReqValid_o, 1'b0);
    chk("mid_rst_req_addr", memReqAddr_o, '0);
    chk("mid_rst_blk", instBlock_o, '0);
    chk("mid_rst_wr_en", wrEnable_o, 1'b0);
    step(); step();
    reset = 1'b1;
    for (int b = 0; b < NB; b++) begin
      memRspValid_i = 1'b1; memRspData_i = {$urandom(), $urandom()}; step();
    end
    memRspValid_i = 1'b0; step();
    chk("stray_busy", busy_o, 1'b0);
    chk("stray_blk", instBlock_o, '0);
    chk_writes(0, '0, '0);

    for (int it = 0; it < 24; it++) begin
      ck = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      co = (ck >= 0 && ck < 3) ? 1'($urandom_range(1, 0)) : 1'b0;
      refill($urandom(), $urandom_range(4, 0), 0, $urandom_range(3, 0), ck, co,
             1'($urandom_range(1, 0)), 1'b0);
    end

    chk("tmo_before", timeout_o, 1'b0);
    miss_i = 1'b1; missAddr_i = 32'h0000_3000; step(); miss_i = 1'b0;
    memReqReady_i = 1'b1; step(); memReqReady_i = 1'b0;
    for (int i = 0; i < 1100; i++) step();
`ifdef REFILL_TIMEOUT_EN
    chk("tmo_flag", timeout_o, 1'b1);
    chk("tmo_busy", busy_o, 1'b0);
    chk_writes(0, '0, '0);
`else
    chk("tmo_flag", timeout_o, 1'b0);
    chk("tmo_busy", busy_o, 1'b1);
    for (int b = 0; b < NB; b++) begin
      memRspValid_i = 1'b1; memRspData_i = 64'(b + 1); step();
    end
    memRspValid_i = 1'b0;
    chk("late_wr_en", wrEnable_o, 1'b1);
    step();
    chk_writes(1, 32'h0000_3000, {64'd4, 64'd3, 64'd2, 64'd1});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter BEAT_WIDTH, default 64: data bits per memory response beat.
REQ-002 SHALL have parameter NUM_BEATS, default `CACHE_WIDTH/BEAT_WIDTH (4): beats per cache block.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port miss_i  in  1  L1 I-cache miss for current fetch PC.
REQ-006 SHALL have port missAddr_i  in  `SIZE_PC  missing fetch address.
REQ-007 SHALL have port cancel_i  in  1  fetch redirect (recover/exception); abandon pending fill.
REQ-008 SHALL have port memReqValid_o  out  1  refill request valid.
REQ-009 SHALL have port memReqReady_i  in  1  memory accepts request.
REQ-010 SHALL have port memReqAddr_o  out  `SIZE_PC  block-aligned request address.
REQ-011 SHALL have port memRspValid_i  in  1  response beat valid; always accepted, no backpressure.
REQ-012 SHALL have port memRspData_i  in  BEAT_WIDTH  response beat data.
REQ-013 SHALL have port wrEnable_o  out  1  one-cycle cache write strobe.
REQ-014 SHALL have port wrAddr_o  out  `SIZE_PC  block address written.
REQ-015 SHALL have port instBlock_o  out  `CACHE_WIDTH  assembled block.
REQ-016 SHALL have port busy_o  out  1  refill in progress (state != IDLE).
REQ-017 SHALL have port timeout_o  out  1  sticky refill-timeout flag.

Function
REQ-018 SHALL implement states IDLE, REQ, FILL, WRITE, DRAIN.
REQ-019 IDLE: on miss_i=1 and cancel_i=0, SHALL latch missAddr_i with low log2(`CACHE_WIDTH/8) bits cleared and go to REQ next cycle.
REQ-020 REQ: memReqValid_o=1, memReqAddr_o=latched address, held stable until memReqValid_o&memReqReady_i, then FILL.
REQ-021 FILL: each memRspValid_i stores memRspData_i into beat slot = beat counter (beat 0 = bits BEAT_WIDTH-1:0), counter increments modulo NUM_BEATS.
REQ-022 Final beat (counter = NUM_BEATS-1 with valid) SHALL move to WRITE.
REQ-023 WRITE: wrEnable_o=1 exactly one cycle, wrAddr_o=latched address, instBlock_o=assembled block; then IDLE.
REQ-024 miss_i in any non-IDLE state SHALL be ignored; no request queueing.
REQ-025 cancel_i in REQ before handshake SHALL return to IDLE with no request issued that cycle; if handshake and cancel coincide, go to DRAIN.
REQ-026 cancel_i in FILL SHALL go to DRAIN, keeping beat count; a beat arriving that cycle still counts.
REQ-027 DRAIN: consume remaining beats, discard, wrEnable_o never asserted; go IDLE after final beat.
REQ-028 cancel_i in WRITE or DRAIN SHALL have no effect.
REQ-029 Request-to-write latency SHALL be exactly 1 cycle after the final beat.
REQ-030 wrEnable_o, memReqValid_o SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-031 On reset low, asynchronously: state=IDLE, beat counter=0, latched address=0, block register=0, all outputs 0.
REQ-032 Reset mid-refill SHALL discard the fill; beats arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-033 With REFILL_TIMEOUT_EN defined: 10-bit counter, cleared on every accepted beat or state entry, increments in REQ/FILL/DRAIN; reaching 1023 sets timeout_o (sticky until reset) and forces IDLE without write.
REQ-034 Without REFILL_TIMEOUT_EN: no counter logic, timeout_o tied 0, controller waits indefinitely.

Structure
REQ-035 State encoding enum, BEAT_WIDTH/NUM_BEATS defaults, timeout limit SHALL live in the shared fetch package; `SIZE_PC/`CACHE_WIDTH from the existing global defines.
REQ-036 Beat assembly (counter + block shift/slot register) SHALL be sub-module refill_beat_buffer; FSM stays in icache_refill_ctrl.

Verification
REQ-037 Miss at 0x0000_1234, ready same cycle, 4 beats 0xA..0xD back-to-back -> memReqAddr_o=0x0000_1220, wrEnable_o one cycle after beat 4, instBlock_o={D,C,B,A}.
REQ-038 Ready delayed 5 cycles, beats with 2-cycle gaps -> memReqValid_o and address stable throughout, single write, busy_o deasserts cycle after write.
REQ-039 cancel_i after beat 2 -> DRAIN, beats 3-4 consumed, wrEnable_o stays 0, IDLE after beat 4, next miss serviced normally.
REQ-040 Second miss_i (0x2000) during FILL of 0x1220 -> ignored, only 0x1220 written.
REQ-041 Reset asserted in FILL after beat 1 -> all outputs 0 immediately, stray beats after release ignored.
REQ-042 REFILL_TIMEOUT_EN defined, no response for 1023 cycles after handshake -> timeout_o=1, IDLE, no write; undefined -> still in FILL, timeout_o=0.
